// File: rtl/spi_pkg.sv
// Shared types and limits for the SPI MOSI receiver.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_rx_state_t;

    localparam int SPI_MAX_WIDTH = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered edge detection; level, rise and fall
// are mutually aligned so downstream logic sees a consistent snapshot.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_last <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_last <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_last;
            r_fall <= ~r_sync[STAGES-1] & r_last;
        end
    end

    assign level = r_last;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/spi_mosi_receiver.sv
// SPI slave receive path (MOSI only), fully in the sys_clk domain with a
// ready/valid word output plus overrun and frame-error pulses.
module spi_mosi_receiver
    import spi_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LSB_FIRST   = 0
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    input  logic             spi_cs_n,
    input  logic             cpol,
    input  logic             cpha,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             rx_frame_err,
    output logic             busy
);

    localparam int CNT_W    = $clog2(WIDTH + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 3);
    localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 2);

    spi_rx_state_t    r_state;
    spi_rx_state_t    w_state_next;
    logic             r_cpol;
    logic             r_cpha;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] r_word;
    logic             r_word_done;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic [SETTLE_W-1:0] r_settle;
    logic             r_armed;

    logic w_clk_level, w_clk_rise, w_clk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_sample_edge, w_sample_en, w_start, w_stop;
    logic w_unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .i_clk(sys_clk), .i_reset_n(sys_reset_n), .i_d(spi_clk),
        .level(w_clk_level), .rise(w_clk_rise), .fall(w_clk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(sys_clk), .i_reset_n(sys_reset_n), .i_d(spi_mosi),
        .level(w_mosi), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(sys_clk), .i_reset_n(sys_reset_n), .i_d(spi_cs_n),
        .level(w_cs_level), .rise(w_cs_rise), .fall(w_cs_fall)
    );

    assign w_unused_edges = &{1'b0, w_clk_level, w_mosi_rise, w_mosi_fall};

    assign w_sample_edge = (r_cpol ^ r_cpha) ? w_clk_fall : w_clk_rise;
    assign w_start       = (r_state == IDLE) && w_cs_fall && r_armed;
    assign w_stop        = (r_state == ACTIVE) && w_cs_rise;
    assign w_sample_en   = (r_state == ACTIVE) && !w_cs_rise && w_sample_edge;

    // A CS fall seen while the cs synchroniser is still refilling after reset
    // is an artefact of the reset value; only arm once CS is seen deasserted.
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else if (r_settle != SETTLE_DONE) begin
            r_settle <= r_settle + 1'b1;
        end else if (w_cs_level) begin
            r_armed  <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = ACTIVE;
            ACTIVE:  if (w_cs_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ACTIVE);
    end

    always_comb begin
        w_shift_next = r_shift;
        if (LSB_FIRST != 0) begin
            w_shift_next = {w_mosi, r_shift[WIDTH-1:1]};
        end else begin
            w_shift_next = {r_shift[WIDTH-2:0], w_mosi};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_word      <= '0;
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_start) begin
                r_cpol    <= cpol;
                r_cpha    <= cpha;
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_stop) begin
                r_frame_err <= (r_bit_cnt != '0);
                r_bit_cnt   <= '0;
                r_shift     <= '0;
            end else if (w_sample_en) begin
                r_shift <= w_shift_next;
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt   <= '0;
                    r_word      <= w_shift_next;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_word_done) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;

endmodule

// File: doc/spi_mosi_receiver.md
SPI_MOSI_RECEIVER -- requirements
Module: spi_mosi_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bits per word (2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth (>=2).
REQ-003 SHALL have parameter LSB_FIRST, default 0; 0 = MSB first, 1 = LSB first.
REQ-004 SHALL have port sys_clk  in  1  sole clock.
REQ-005 SHALL have port sys_reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port spi_clk  in  1  async SPI clock.
REQ-007 SHALL have port spi_mosi  in  1  async serial data.
REQ-008 SHALL have port spi_cs_n  in  1  async active-low chip select.
REQ-009 SHALL have port cpol  in  1  clock polarity, sampled at CS assertion.
REQ-010 SHALL have port cpha  in  1  clock phase, sampled at CS assertion.
REQ-011 SHALL have port rx_data  out  WIDTH  received word.
REQ-012 SHALL have port rx_valid  out  1  rx_data holds an unconsumed word.
REQ-013 SHALL have port rx_ready  in  1  consumer accepts word.
REQ-014 SHALL have port rx_overrun  out  1  one-cycle pulse, word dropped.
REQ-015 SHALL have port rx_frame_err  out  1  one-cycle pulse, CS released mid-word.
REQ-016 SHALL have port busy  out  1  high in state ACTIVE.

Function
REQ-017 spi_clk, spi_mosi and spi_cs_n SHALL each pass through a SYNC_STAGES-flop chain clocked by sys_clk; all logic SHALL be in the sys_clk domain, with no derived clocks.
REQ-018 Edges SHALL be detected from the last two synchroniser flops; sys_clk frequency SHALL be at least 4x spi_clk.
REQ-019 The FSM SHALL have states IDLE and ACTIVE.
REQ-020 IDLE->ACTIVE SHALL occur on a synced cs_n falling edge, latching cpol/cpha and clearing the bit counter and shift register.
REQ-021 ACTIVE->IDLE SHALL occur on a synced cs_n rising edge.
REQ-022 The sample edge SHALL be rising spi_clk when cpol^cpha==0, otherwise falling; the other edge SHALL be ignored.
REQ-023 Each sample edge in ACTIVE SHALL shift synced mosi into the shift register (left if LSB_FIRST=0, right if 1) and increment the bit counter.
REQ-024 When the counter reaches WIDTH it SHALL wrap to 0; the frame continues, so multi-word frames are supported.
REQ-025 On word completion, if rx_valid==0 or rx_ready==1 in that cycle, rx_data SHALL load the word and rx_valid SHALL be 1 the next cycle.
REQ-026 On word completion otherwise, the word SHALL be dropped, rx_data SHALL be held, and rx_overrun SHALL pulse for one cycle.
REQ-027 rx_valid SHALL clear the cycle after rx_valid&&rx_ready unless a new word loads in the same cycle.
REQ-028 Latency: rx_valid SHALL rise exactly SYNC_STAGES+2 sys_clk cycles after the first sys_clk edge that captures the WIDTH-th sample edge at the pin.
REQ-029 A CS rising edge with bit counter !=0 SHALL pulse rx_frame_err for one cycle and discard the partial word.
REQ-030 A CS rising edge with bit counter ==0 SHALL produce no error.
REQ-031 If a CS rising edge and a sample edge are detected in the same cycle, CS SHALL win and the sample SHALL be ignored.
REQ-032 spi_clk edges in IDLE SHALL be ignored.
REQ-033 cpol/cpha changes while ACTIVE SHALL have no effect until the next CS assertion.

Reset
REQ-034 While sys_reset_n==0 at a sys_clk edge, the FSM SHALL go to IDLE and the counter and shift register SHALL clear.
REQ-035 During reset, rx_data SHALL be 0 and rx_valid, rx_overrun, rx_frame_err and busy SHALL be 0.
REQ-036 During reset, the synchronisers SHALL load spi_clk=0, mosi=0 and cs_n=1.
REQ-037 Reset mid-frame SHALL abort the frame without a frame error; the block SHALL resume only on a fresh CS falling edge.

Structure
REQ-038 Package spi_pkg SHALL hold typedef spi_rx_state_t {IDLE, ACTIVE} and localparam SPI_MAX_WIDTH=32.
REQ-039 One sub-module, spi_sync_edge (parameter STAGES, reset value; outputs level, rise, fall), SHALL be instantiated three times.

Verification
REQ-040 Bench SHALL cover: mode 0, WIDTH=16, send 0xA5C3, rx_ready=1 -> rx_data=0xA5C3, rx_valid high for 1 cycle, no error pulses.
REQ-041 Bench SHALL cover: mode 3 then mode 1, send 0x1234 each -> 0x1234 both times; LSB_FIRST=1 build, send bits of 0x1234 LSB first -> 0x1234.
REQ-042 Bench SHALL cover: one CS frame with 0x0001, 0x0002, 0x0003 and rx_ready=0 -> rx_data=0x0001, rx_overrun pulses twice; then rx_ready=1 -> rx_valid drops.
REQ-043 Bench SHALL cover: CS released after 9 of 16 bits -> rx_frame_err pulses once, rx_valid stays 0; the next full frame with 0xFFFF -> 0xFFFF.
REQ-044 Bench SHALL cover: sys_reset_n low for 1 cycle after bit 8 -> all outputs 0, no frame_err; the following frame with 0xBEEF -> 0xBEEF.
REQ-045 Bench SHALL cover: spi_clk toggling with cs_n=1 -> busy=0, rx_valid never asserts.
